// File: rtl/lap_recorder.sv
// Lap/split recorder placed between the BCD time counters and the display scan driver.
// Shows live time, freezes on a split, keeps the most recent 2**IDX_W splits in a
// circular memory and lets the user browse them newest-first in a recall mode.
module lap_recorder #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] time_in,
  input  logic                    clear_state,
  input  logic                    clear_laps,
  input  logic                    lap_pulse,
  input  logic                    recall_pulse,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [IDX_W:0]          lap_count,
  output logic [IDX_W:0]          shown_lap,
  output logic                    frozen,
  output logic                    recall_active,
  output logic                    overflow
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    S_LIVE   = 2'd0,
    S_FROZEN = 2'd1,
    S_RECALL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   r_shown;
  logic [DW-1:0]    r_digits;
  logic             r_frozen;
  logic             r_recall;
  logic             r_overflow;

  // Qualified events after applying the input priority chain
  logic             w_do_clear_laps;
  logic             w_lap;
  logic             w_rec;
  logic             w_has_laps;
  logic             w_full;
  logic             w_write;

  // Display source selection for the next cycle
  logic [IDX_W:0]   w_shown_next;
  logic             w_load_zero;
  logic             w_load_live;
  logic             w_load_mem;
  logic [IDX_W:0]   w_rd_sum;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_do_clear_laps = !clear_state && clear_laps;
  assign w_lap           = !clear_state && !clear_laps && lap_pulse;
  // A recall press coinciding with a lap press is dropped
  assign w_rec           = !clear_state && !clear_laps && !lap_pulse && recall_pulse;
  assign w_has_laps      = (r_count != '0);
  assign w_full          = (r_count == DEPTH_C);
  // Only a split taken from LIVE is recorded; lap presses elsewhere just return to LIVE
  assign w_write         = w_lap && (r_state == S_LIVE);

  // Physical slot of the lap being shown: oldest retained entry plus (shown - 1)
  assign w_rd_sum = {1'b0, r_wr_ptr} - r_count + w_shown_next - ONE_C;
  assign w_rd_idx = w_rd_sum[IDX_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LIVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection following the input priority chain
  always_comb begin
    w_state_next = r_state;
    if (clear_state) begin
      w_state_next = S_LIVE;
    end else if (clear_laps) begin
      if (r_state == S_RECALL) begin
        w_state_next = S_LIVE;
      end
    end else begin
      case (r_state)
        S_LIVE: begin
          if (w_lap) begin
            w_state_next = S_FROZEN;
          end else if (w_rec && w_has_laps) begin
            w_state_next = S_RECALL;
          end
        end
        S_FROZEN: begin
          if (w_lap) begin
            w_state_next = S_LIVE;
          end else if (w_rec && w_has_laps) begin
            w_state_next = S_RECALL;
          end
        end
        S_RECALL: begin
          if (w_lap) begin
            w_state_next = S_LIVE;
          end
        end
        default: w_state_next = S_LIVE;
      endcase
    end
  end

  // Output decode: which value the display register loads and the next shown lap number
  always_comb begin
    w_shown_next = r_shown;
    w_load_zero  = 1'b0;
    w_load_live  = 1'b0;
    w_load_mem   = 1'b0;
    if (clear_state) begin
      w_shown_next = '0;
      w_load_zero  = 1'b1;
    end else if (clear_laps) begin
      if (r_state == S_RECALL) begin
        w_shown_next = '0;
        w_load_live  = 1'b1;
      end else if (r_state == S_LIVE) begin
        w_load_live  = 1'b1;
      end
    end else begin
      case (r_state)
        S_LIVE: begin
          if (w_rec && w_has_laps) begin
            w_shown_next = r_count;
            w_load_mem   = 1'b1;
          end else begin
            // Includes the split itself: the frozen value is the time sampled on the press
            w_load_live  = 1'b1;
          end
        end
        S_FROZEN: begin
          if (w_lap) begin
            w_load_live  = 1'b1;
          end else if (w_rec && w_has_laps) begin
            w_shown_next = r_count;
            w_load_mem   = 1'b1;
          end
        end
        S_RECALL: begin
          if (w_lap) begin
            w_shown_next = '0;
            w_load_live  = 1'b1;
          end else if (w_rec) begin
            // Step towards older laps, wrapping from the oldest back to the newest
            w_shown_next = (r_shown == ONE_C) ? r_count : (r_shown - ONE_C);
            w_load_mem   = 1'b1;
          end
        end
        default: begin
          w_shown_next = '0;
          w_load_zero  = 1'b1;
        end
      endcase
    end
  end

  // Registered display value, shown lap number and state flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_shown  <= '0;
      r_frozen <= 1'b0;
      r_recall <= 1'b0;
    end else begin
      if (w_load_zero) begin
        r_digits <= '0;
      end else if (w_load_live) begin
        r_digits <= time_in;
      end else if (w_load_mem) begin
        r_digits <= r_mem[w_rd_idx];
      end
      r_shown  <= w_shown_next;
      r_frozen <= (w_state_next == S_FROZEN);
      r_recall <= (w_state_next == S_RECALL);
    end
  end

  // Write pointer, stored-lap count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_do_clear_laps) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_write) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + ONE_C;
      end
    end
  end

  // Lap memory write port; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= time_in;
    end
  end

  assign digits_out    = r_digits;
  assign lap_count     = r_count;
  assign shown_lap     = r_shown;
  assign frozen        = r_frozen;
  assign recall_active = r_recall;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder at default parameters (4 digits, 8-entry lap memory).
module tb_lap_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] time_in = '0;
  logic        clear_state = 1'b0;
  logic        clear_laps = 1'b0;
  logic        lap_pulse = 1'b0;
  logic        recall_pulse = 1'b0;
  logic [15:0] digits_out;
  logic [3:0]  lap_count;
  logic [3:0]  shown_lap;
  logic        frozen;
  logic        recall_active;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  lap_recorder #(.NUM_DIGITS(4), .IDX_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .time_in      (time_in),
    .clear_state  (clear_state),
    .clear_laps   (clear_laps),
    .lap_pulse    (lap_pulse),
    .recall_pulse (recall_pulse),
    .digits_out   (digits_out),
    .lap_count    (lap_count),
    .shown_lap    (shown_lap),
    .frozen       (frozen),
    .recall_active(recall_active),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_lap();
    lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
  endtask

  task automatic pulse_recall();
    recall_pulse = 1'b1;
    tick();
    recall_pulse = 1'b0;
  endtask

  task automatic pulse_clear_laps();
    clear_laps = 1'b1;
    tick();
    clear_laps = 1'b0;
  endtask

  // Record one split and release back to LIVE
  task automatic record(input logic [15:0] v);
    time_in = v;
    pulse_lap();
    pulse_lap();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    time_in = 16'h0123;
    tick();
    tick();
    n_checks++; if (digits_out !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits_out); else n_pass++;
    n_checks++; if ({lap_count, shown_lap} !== 8'h00) $display("FAIL reset_counts: got count=%0d shown=%0d want 0/0", lap_count, shown_lap); else n_pass++;
    n_checks++; if ({frozen, recall_active, overflow} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {frozen, recall_active, overflow}); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (digits_out !== 16'h0123) $display("FAIL live_path: got %h want 0123", digits_out); else n_pass++;
    n_checks++; if ({frozen, recall_active} !== 2'b00) $display("FAIL live_state: got %b want 00", {frozen, recall_active}); else n_pass++;
    $display("reset/live: digits=%h", digits_out);
  endtask

  task automatic test_lap_freeze();
    time_in = 16'h0512;
    pulse_lap();
    time_in = 16'h0513;
    tick();
    n_checks++; if (digits_out !== 16'h0512) $display("FAIL freeze_digits: got %h want 0512", digits_out); else n_pass++;
    n_checks++; if (frozen !== 1'b1) $display("FAIL freeze_flag: got %b want 1", frozen); else n_pass++;
    n_checks++; if (lap_count !== 4'd1) $display("FAIL freeze_count: got %0d want 1", lap_count); else n_pass++;
    time_in = 16'h0600;
    pulse_lap();
    tick();
    n_checks++; if (digits_out !== 16'h0600) $display("FAIL release_digits: got %h want 0600", digits_out); else n_pass++;
    n_checks++; if ({frozen, lap_count} !== 5'b0_0001) $display("FAIL release_state: got frozen=%b count=%0d want 0/1", frozen, lap_count); else n_pass++;
    $display("lap freeze/release: digits=%h count=%0d", digits_out, lap_count);
  endtask

  task automatic test_recall_browse();
    logic [3:0]  exp_shown [4];
    logic [15:0] exp_dig   [4];
    exp_shown = '{4'd3, 4'd2, 4'd1, 4'd3};
    exp_dig   = '{16'h0003, 16'h0002, 16'h0001, 16'h0003};
    pulse_clear_laps();
    record(16'h0001);
    record(16'h0002);
    record(16'h0003);
    n_checks++; if (lap_count !== 4'd3) $display("FAIL browse_count: got %0d want 3", lap_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pulse_recall();
      n_checks++; if (shown_lap !== exp_shown[i]) $display("FAIL browse_shown_%0d: got %0d want %0d", i, shown_lap, exp_shown[i]); else n_pass++;
      n_checks++; if (digits_out !== exp_dig[i]) $display("FAIL browse_digits_%0d: got %h want %h", i, digits_out, exp_dig[i]); else n_pass++;
      n_checks++; if (recall_active !== 1'b1) $display("FAIL browse_active_%0d: got %b want 1", i, recall_active); else n_pass++;
      $display("recall step %0d: shown=%0d digits=%h", i, shown_lap, digits_out);
    end
    time_in = 16'h0777;
    pulse_lap();
    tick();
    n_checks++; if ({recall_active, frozen, shown_lap} !== 6'b00_0000) $display("FAIL browse_exit: got active=%b frozen=%b shown=%0d want 0/0/0", recall_active, frozen, shown_lap); else n_pass++;
    n_checks++; if (digits_out !== 16'h0777) $display("FAIL browse_exit_digits: got %h want 0777", digits_out); else n_pass++;
  endtask

  task automatic test_overflow();
    pulse_clear_laps();
    for (int v = 1; v <= 8; v++) record(16'(v));
    n_checks++; if ({lap_count, overflow} !== 5'b1000_0) $display("FAIL full_no_ovf: got count=%0d ovf=%b want 8/0", lap_count, overflow); else n_pass++;
    record(16'h0009);
    n_checks++; if ({lap_count, overflow} !== 5'b1000_1) $display("FAIL overflow: got count=%0d ovf=%b want 8/1", lap_count, overflow); else n_pass++;
    // After the wrap, lap number k (1 = oldest) holds value k+1
    for (int k = 8; k >= 1; k--) begin
      pulse_recall();
      n_checks++; if (shown_lap !== 4'(k) || digits_out !== 16'(k + 1)) $display("FAIL ovf_recall_%0d: got shown=%0d digits=%h want %0d/%h", k, shown_lap, digits_out, k, 16'(k + 1)); else n_pass++;
      $display("overflow recall: shown=%0d digits=%h", shown_lap, digits_out);
    end
    pulse_lap();
  endtask

  task automatic test_clear_state();
    time_in = 16'h0042;
    pulse_lap();
    n_checks++; if (frozen !== 1'b1) $display("FAIL cs_setup_frozen: got %b want 1", frozen); else n_pass++;
    clear_state = 1'b1;
    lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
    n_checks++; if (digits_out !== 16'h0000) $display("FAIL cs_digits: got %h want 0000", digits_out); else n_pass++;
    n_checks++; if ({frozen, recall_active, lap_count} !== 6'b00_1000) $display("FAIL cs_state: got frozen=%b active=%b count=%0d want 0/0/8", frozen, recall_active, lap_count); else n_pass++;
    pulse_recall();
    n_checks++; if ({recall_active, shown_lap, digits_out} !== 21'h0) $display("FAIL cs_recall_ignored: got active=%b shown=%0d digits=%h want 0/0/0000", recall_active, shown_lap, digits_out); else n_pass++;
    clear_state = 1'b0;
    tick();
    n_checks++; if (digits_out !== 16'h0042) $display("FAIL cs_release: got %h want 0042", digits_out); else n_pass++;
    $display("clear_state: digits=%h count=%0d", digits_out, lap_count);
  endtask

  task automatic test_empty_clear();
    pulse_clear_laps();
    n_checks++; if ({lap_count, overflow} !== 5'b0000_0) $display("FAIL clear_empty: got count=%0d ovf=%b want 0/0", lap_count, overflow); else n_pass++;
    pulse_recall();
    n_checks++; if ({recall_active, frozen} !== 2'b00) $display("FAIL empty_recall: got active=%b frozen=%b want 0/0", recall_active, frozen); else n_pass++;
    record(16'h0011);
    record(16'h0022);
    pulse_recall();
    n_checks++; if ({recall_active, shown_lap} !== 5'b1_0010 || digits_out !== 16'h0022) $display("FAIL pre_clear_recall: got active=%b shown=%0d digits=%h want 1/2/0022", recall_active, shown_lap, digits_out); else n_pass++;
    pulse_clear_laps();
    n_checks++; if ({recall_active, lap_count, overflow, shown_lap} !== 10'b0) $display("FAIL clear_in_recall: got active=%b count=%0d ovf=%b shown=%0d want 0/0/0/0", recall_active, lap_count, overflow, shown_lap); else n_pass++;
    record(16'h0033);
    pulse_recall();
    n_checks++; if ({shown_lap, lap_count} !== 8'h11 || digits_out !== 16'h0033) $display("FAIL slot0_after_clear: got shown=%0d count=%0d digits=%h want 1/1/0033", shown_lap, lap_count, digits_out); else n_pass++;
    pulse_lap();
    $display("empty/clear: count=%0d", lap_count);
  endtask

  task automatic test_back_to_back();
    time_in = 16'h0101;
    lap_pulse = 1'b1;
    recall_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
    recall_pulse = 1'b0;
    n_checks++; if ({frozen, recall_active, lap_count} !== 6'b10_0010) $display("FAIL lap_beats_recall: got frozen=%b active=%b count=%0d want 1/0/2", frozen, recall_active, lap_count); else n_pass++;
    n_checks++; if (digits_out !== 16'h0101) $display("FAIL lap_beats_recall_digits: got %h want 0101", digits_out); else n_pass++;
    $display("lap+recall together: frozen=%b count=%0d", frozen, lap_count);
  endtask

  initial begin
    test_reset();
    test_lap_freeze();
    test_recall_browse();
    test_overflow();
    test_clear_state();
    test_empty_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Parametrised successor to the stopwatch lap/display mux.
- Sits between the BCD time counters and the 7-segment scan driver.
- Passes live time to the display, freezes the display on a lap split, and stores each split in a circular lap memory.
- Stored laps can be browsed in a recall mode.

Parameters:
NUM_DIGITS, 4, number of 4-bit BCD digits per time value
IDX_W, 3, lap memory index width; DEPTH = 2**IDX_W stored laps (8 at default)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
time_in  input  4*NUM_DIGITS  live BCD time; digit 0 in bits [3:0]
clear_state  input  1  stopwatch in reset state (level); forces zero display
clear_laps  input  1  single-cycle pulse; empties lap memory
lap_pulse  input  1  single-cycle pulse from the one-pulse block; lap/split button
recall_pulse  input  1  single-cycle pulse; enter recall or step to the previous lap
digits_out  output  4*NUM_DIGITS  registered display value
lap_count  output  IDX_W+1  number of laps stored, 0..DEPTH
shown_lap  output  IDX_W+1  lap number displayed in RECALL (1 = oldest retained); 0 otherwise
frozen  output  1  high in FROZEN
recall_active  output  1  high in RECALL
overflow  output  1  sticky; set when a lap overwrites the oldest entry

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs go to 0 and the state goes to LIVE.
  - wr_ptr=0, count=0.
  - Memory contents are don't-care.
- Priority per cycle: rst > clear_state > clear_laps > lap_pulse > recall_pulse.
- States: LIVE, FROZEN, RECALL. All outputs are registered.
- clear_state=1:
  - State goes to LIVE and digits_out becomes 0 next cycle.
  - lap_pulse and recall_pulse are ignored.
  - Memory and count are untouched.
- clear_laps:
  - Sets count=0, wr_ptr=0, overflow=0.
  - If in RECALL, the state goes to LIVE.
  - Any lap_pulse or recall_pulse in the same cycle is ignored.
- LIVE:
  - digits_out = time_in of the previous cycle (1-cycle latency).
  - lap_pulse at cycle T:
    - mem[wr_ptr] <= time_in(T); wr_ptr++ (wraps mod DEPTH).
    - If count < DEPTH, count++. Otherwise count stays DEPTH, overflow <= 1 and the oldest lap is overwritten.
    - digits_out at T+1 = time_in(T); state goes to FROZEN.
  - recall_pulse with count>0 enters RECALL; with count==0 it is ignored.
- FROZEN:
  - digits_out holds.
  - lap_pulse returns to LIVE; no record is made, and live time shows from the next cycle.
  - recall_pulse with count>0 enters RECALL.
- RECALL:
  - On entry, shows the newest lap: shown_lap=count, digits_out=mem[wr_ptr-1] on the next cycle.
  - recall_pulse decrements shown_lap; from 1 it wraps to count.
  - Physical index = (wr_ptr - count + shown_lap - 1) mod DEPTH.
  - lap_pulse returns to LIVE with no record made; shown_lap <= 0.
- Simultaneous lap_pulse and recall_pulse: lap_pulse acts, recall_pulse is dropped.
- Time counters continue externally in every state; this block never stalls them.
- Flag outputs:
  - frozen and recall_active track the state, updated in the same cycle as the state register.
  - lap_count mirrors count.
- Pointer and count arithmetic is unsigned, width IDX_W or IDX_W+1, with natural wrap mod DEPTH.

Test Plan:
- Reset and live path:
  - rst held 2 cycles, then time_in=16'h0123 -> all outputs 0 during reset.
  - digits_out=16'h0123 one cycle after release; state LIVE.
- Lap freeze and release:
  - lap_pulse with time_in=16'h0512, then time_in advances -> digits_out stays 16'h0512, frozen=1, lap_count=1.
  - Second lap_pulse -> LIVE, live time resumes, lap_count=1.
- Recall browse:
  - Record laps 16'h0001, 16'h0002, 16'h0003, then recall_pulse x4 -> shown_lap 3,2,1,3.
  - Matching digits_out 0003,0002,0001,0003.
  - lap_pulse -> LIVE, shown_lap=0.
- Overflow (IDX_W=3):
  - Record 9 laps with values 1..9 -> lap_count=8, overflow=1.
  - Recall shows 9 first; stepping down to shown_lap=1 shows 2.
- clear_state dominance:
  - In FROZEN, assert clear_state together with lap_pulse -> digits_out=0, state LIVE, lap_count unchanged.
  - recall_pulse while clear_state=1 is ignored.
- Empty and clear:
  - recall_pulse with count=0 -> stays LIVE.
  - clear_laps in RECALL -> LIVE, lap_count=0, overflow=0.
  - Next lap_pulse writes slot 0.
